// File: rtl/sw_pkg.sv
// Shared types and default dimensions for the Smith-Waterman score datapath.
package sw_pkg;

    localparam int SW_READ_LEN = 128;
    localparam int SW_REF_LEN  = 128;
    localparam int SW_SCORE_W  = 10;

    typedef logic [SW_SCORE_W-1:0] score_t;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

endpackage

// File: rtl/sw_max_tracker.sv
// Best-score register: captures score and (i,j) on a strictly greater accepted write; ties keep the
// earlier position. Result is visible the cycle after the write, and the tracker never stalls.
module sw_max_tracker #(
    parameter int SCORE_W = 10,
    parameter int IDX_W   = 8,
    parameter int JDX_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               clr,
    input  logic               upd_vld,
    input  logic [SCORE_W-1:0] upd_score,
    input  logic [IDX_W-1:0]   upd_i,
    input  logic [JDX_W-1:0]   upd_j,
    output logic [SCORE_W-1:0] max_score,
    output logic [IDX_W-1:0]   max_i,
    output logic [JDX_W-1:0]   max_j
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            max_score <= '0;
            max_i     <= '0;
            max_j     <= '0;
        end else if (clr) begin
            max_score <= '0;
            max_i     <= '0;
            max_j     <= '0;
        end else if (upd_vld && (upd_score > max_score)) begin
            max_score <= upd_score;
            max_i     <= upd_i;
            max_j     <= upd_j;
        end
    end

endmodule

// File: rtl/sw_score_store.sv
// SW DP score grid with zero row/column boundaries: 1-cycle reads with write-first bypass, row-per-cycle
// clear sweep (o_ready low while sweeping), sticky range error; SW_SCORE_MAX_TRACK_EN adds a best-score tracker.
module sw_score_store
    import sw_pkg::*;
#(
    parameter int READ_LEN = SW_READ_LEN,
    parameter int REF_LEN  = SW_REF_LEN,
    parameter int SCORE_W  = SW_SCORE_W,
    parameter int IDX_W    = $clog2(READ_LEN) + 1,
    parameter int JDX_W    = $clog2(REF_LEN) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    output logic               o_ready,
    input  logic               i_wr_valid,
    input  logic [IDX_W-1:0]   i_wr_i,
    input  logic [JDX_W-1:0]   i_wr_j,
    input  logic [SCORE_W-1:0] i_wr_score,
    input  logic               i_rd_valid,
    input  logic [IDX_W-1:0]   i_rd_i,
    input  logic [JDX_W-1:0]   i_rd_j,
    output logic               o_rd_valid,
    output logic [SCORE_W-1:0] o_rd_score,
    output logic               o_err,
    output logic [SCORE_W-1:0] o_max_score,
    output logic [IDX_W-1:0]   o_max_i,
    output logic [JDX_W-1:0]   o_max_j
);

    localparam int RA_W = (READ_LEN > 1) ? $clog2(READ_LEN) : 1;
    localparam int CA_W = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;

    // Only rows/cols 1..N are stored; physical index is logical index minus one.
    logic [SCORE_W-1:0] mem [READ_LEN][REF_LEN];

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] row_cnt;
    logic             ready;
    logic             wr_in_range;
    logic             wr_ok;
    logic             wr_bad;
    logic             rd_oor;
    logic             rd_zero;
    logic             rd_go;
    logic             rd_bad;
    logic             bypass;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (!i_clear && (row_cnt == IDX_W'(READ_LEN))) state_nxt = S_READY;
            S_READY: if (i_clear) state_nxt = S_CLEAR;
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        ready = (state == S_READY);
    end

    assign o_ready = ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_cnt <= IDX_W'(1);
        end else if ((state == S_CLEAR) && !i_clear && (row_cnt != IDX_W'(READ_LEN))) begin
            row_cnt <= row_cnt + IDX_W'(1);
        end else begin
            row_cnt <= IDX_W'(1);
        end
    end

    assign wr_in_range = (i_wr_i != '0) && (i_wr_i <= IDX_W'(READ_LEN)) &&
                         (i_wr_j != '0) && (i_wr_j <= JDX_W'(REF_LEN));
    assign wr_ok   = ready && i_wr_valid && wr_in_range;
    assign wr_bad  = ready && i_wr_valid && !wr_in_range;
    assign rd_oor  = (i_rd_i > IDX_W'(READ_LEN)) || (i_rd_j > JDX_W'(REF_LEN));
    assign rd_zero = (i_rd_i == '0) || (i_rd_j == '0);
    assign rd_go   = ready && i_rd_valid;
    assign rd_bad  = rd_go && rd_oor;
    assign bypass  = wr_ok && (i_wr_i == i_rd_i) && (i_wr_j == i_rd_j);

    // Storage has no reset; the sweep launched by reset/i_clear is what zeroes it.
    always_ff @(posedge i_clk) begin
        if (state == S_CLEAR) begin
            for (int j = 0; j < REF_LEN; j++) begin
                mem[RA_W'(row_cnt - IDX_W'(1))][CA_W'(j)] <= '0;
            end
        end else if (wr_ok) begin
            mem[RA_W'(i_wr_i - IDX_W'(1))][CA_W'(i_wr_j - JDX_W'(1))] <= i_wr_score;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_valid <= 1'b0;
            o_rd_score <= '0;
        end else begin
            o_rd_valid <= rd_go;
            if (!rd_go || rd_oor || rd_zero) begin
                o_rd_score <= '0;
            end else if (bypass) begin
                o_rd_score <= i_wr_score;
            end else begin
                o_rd_score <= mem[RA_W'(i_rd_i - IDX_W'(1))][CA_W'(i_rd_j - JDX_W'(1))];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (i_clear) begin
            o_err <= 1'b0;
        end else if (wr_bad || rd_bad) begin
            o_err <= 1'b1;
        end
    end

`ifdef SW_SCORE_MAX_TRACK_EN
    sw_max_tracker #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W),
        .JDX_W   (JDX_W)
    ) u_max_tracker (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .clr       (i_clear),
        .upd_vld   (wr_ok),
        .upd_score (i_wr_score),
        .upd_i     (i_wr_i),
        .upd_j     (i_wr_j),
        .max_score (o_max_score),
        .max_i     (o_max_i),
        .max_j     (o_max_j)
    );
`else
    assign o_max_score = '0;
    assign o_max_i     = '0;
    assign o_max_j     = '0;
`endif

endmodule

// File: doc/sw_score_store.md
Name: sw_score_store

Overview:
- Parametrised Smith-Waterman DP score storage for the SW alignment datapath. Replaces the fixed 128x128, shared-port score matrix.
- Holds an (READ_LEN+1) x (REF_LEN+1) score grid. Row 0 and column 0 are hard-wired zero boundaries and are never stored.
- Provides independent write and read ports, 1-cycle read latency with read-after-write bypass, a multi-cycle clear sweep and an out-of-range error flag.
- Sits between the DP cell PE and the traceback controller.

Parameters:
READ_LEN, 128, maximum read length; valid rows 1..READ_LEN.
REF_LEN, 128, maximum reference length; valid columns 1..REF_LEN.
SCORE_W, 10, score bit width (unsigned).
IDX_W, $clog2(READ_LEN)+1, row index width (derived).
JDX_W, $clog2(REF_LEN)+1, column index width (derived).

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_clear  in  1  pulse: start clear sweep
o_ready  out  1  high when the store accepts reads/writes
i_wr_valid  in  1  write strobe
i_wr_i  in  IDX_W  write row
i_wr_j  in  JDX_W  write column
i_wr_score  in  SCORE_W  write data
i_rd_valid  in  1  read strobe
i_rd_i  in  IDX_W  read row
i_rd_j  in  JDX_W  read column
o_rd_valid  out  1  read data valid
o_rd_score  out  SCORE_W  read data
o_err  out  1  sticky out-of-range flag
o_max_score  out  SCORE_W  best score (optional feature)
o_max_i  out  IDX_W  row of best score (optional feature)
o_max_j  out  JDX_W  column of best score (optional feature)

Behaviour:
- Reset values: state=S_CLEAR, row counter=1, o_ready=0, o_rd_valid=0, o_rd_score=0, o_err=0, max outputs=0. Storage cells have no reset; reset launches the clear sweep.
- S_CLEAR:
  - Each cycle zeroes one full row (row counter 1..READ_LEN), so the sweep takes READ_LEN cycles.
  - o_ready=0. Writes are ignored. Reads return o_rd_valid=0.
  - After row READ_LEN is zeroed, go to S_READY.
- S_READY: o_ready=1.
  - i_clear=1 returns to S_CLEAR with row counter=1 and clears o_err and the max tracker.
  - i_clear during S_CLEAR restarts the sweep at row 1.
- Write, in S_READY, i_wr_valid=1 with 1<=i_wr_i<=READ_LEN and 1<=i_wr_j<=REF_LEN: the cell is updated at the clock edge.
- Read, in S_READY, i_rd_valid=1: o_rd_valid=1 and o_rd_score are presented the next cycle (latency 1). o_rd_valid=0 in any cycle without a read.
  - Row 0 or column 0 reads return 0 with no error.
  - In-range reads return the stored value.
- Simultaneous read and write to the same in-range address: the read returns i_wr_score (write-first bypass).
- Out of range (row>READ_LEN or col>REF_LEN) on either port:
  - The write is dropped. The read returns 0 with o_rd_valid=1.
  - o_err is set and stays set until reset or i_clear.
- A write to row 0 or column 0 is dropped and sets o_err.
- Asynchronous reset mid-sweep or mid-read: outputs go to their reset values immediately and the sweep restarts from row 1.
- No arithmetic on scores; widths pass through unchanged.

Optional Feature:
- Macro: SW_SCORE_MAX_TRACK_EN.
- Defined:
  - On every accepted in-range write with i_wr_score > o_max_score (strictly greater), the next cycle updates o_max_score, o_max_i and o_max_j.
  - Ties keep the earlier position.
  - Cleared by reset and by i_clear.
- Undefined: o_max_score, o_max_i and o_max_j are tied to 0 and no tracker logic is generated.

Decomposition:
- Shared package sw_pkg:
  - State enum (S_CLEAR, S_READY).
  - Default SW_READ_LEN, SW_REF_LEN, SW_SCORE_W constants.
  - A typedef for score_t.
- One natural sub-module: sw_max_tracker (compare/update register for the best score and its position), instantiated only under SW_SCORE_MAX_TRACK_EN.

Test Plan:
- Reset release: o_ready=0 for exactly READ_LEN=128 cycles, then 1. A read of (5,7) then returns 0.
- Write (3,4)=10'd77, then read (3,4) next cycle: o_rd_valid=1 and o_rd_score=77 one cycle after the read strobe. Reading (0,4) returns 0 and o_err stays 0.
- Same-cycle write (9,9)=10'd300 and read (9,9): the read returns 300.
- Write (129,1)=10'd5: o_err=1 and the write is dropped. A read of (129,1) returns 0. i_clear then drops o_err to 0 and o_ready is low for 128 cycles.
- With SW_SCORE_MAX_TRACK_EN: writes 50@(2,2), 80@(4,6), 80@(7,7), 20@(8,8) give o_max=80 at (4,6). Without the macro, the max outputs stay 0.
- Assert i_rst during the clear sweep at row 60, release it, and check the full 128-cycle sweep repeats. Pre-reset writes to (100,100) read back 0.
